dt_pack: RTL and testbench
==========================

DT_PACK -- requirements
Module: dt_pack

Interface
REQ-001 Parameter IMG_W, default 128, image width in pixels.
REQ-002 Parameter IMG_H, default 128, image height in pixels.
REQ-003 Parameter WORD_W, default 16, pixels per packed output word.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a pack pass; honoured only in IDLE.
REQ-007 thr  input  8  distance threshold; sampled on the accepted start cycle.
REQ-008 busy  output  1  high from the cycle after accepted start until done, inclusive.
REQ-009 done  output  1  one-cycle pulse when the last word is written.
REQ-010 res_rd  output  1  read strobe to the 8-bit distance-map memory.
REQ-011 res_addr  output  14  distance-map pixel address, row-major, addr = row*IMG_W + col.
REQ-012 res_di  input  8  read data; valid in the cycle after res_rd=1 (1-cycle synchronous read).
REQ-013 sti_wr  output  1  write strobe to the 16-bit packed binary-image memory.
REQ-014 sti_addr  output  10  packed word address = pixel_index >> 4.
REQ-015 sti_do  output  16  packed word; bit 15 = lowest pixel index of the word, bit 0 = highest.
REQ-016 ones_cnt  output  15  count of 1-pixels produced in the current/last pass; held after done.

Function
REQ-017 States: IDLE, READ, DRAIN, FIN; all outputs registered.
REQ-018 IDLE -> READ on start=1; thr latched; ones_cnt, pixel address and packer cleared in the same cycle.
REQ-019 READ: res_rd=1 every cycle; res_addr increments 0..16383, one per cycle, no gaps.
REQ-020 READ -> DRAIN in the cycle after res_addr=16383 is issued; DRAIN holds res_rd=0 until the final word is written.
REQ-021 Pixel bit = 1 iff res_di > thr (unsigned, 8-bit compare); shifted into the packer MSB-first.
REQ-022 When the 16th bit of a word is shifted in, the next cycle asserts sti_wr=1 for exactly one cycle with sti_do = the packed word and sti_addr = word index.
REQ-023 Timing, accepted start at cycle 0: res_rd at cycles 1..16384; sti_wr for word k at cycle 16k+18; last write (k=1023) at cycle 16386; done=1 at cycle 16387.
REQ-024 FIN: done=1 for one cycle, then IDLE; busy=0 in IDLE.
REQ-025 ones_cnt increments by 1 per 1-pixel; max 16384, fits in 15 bits, never wraps.
REQ-026 Address counters wrap only at their natural width; no reads beyond 16383, no writes beyond 1023.
REQ-027 start while busy=1 is ignored, with no effect on thr or counters.
REQ-028 start in the FIN cycle is ignored; start is accepted from the following IDLE cycle.
REQ-029 thr=255: all pixels 0, every sti_do=16'h0000, ones_cnt=0.
REQ-030 thr=0: any nonzero distance yields 1.
REQ-031 Outside READ, res_addr holds its last value; outside write cycles, sti_do holds its last value.

Reset
REQ-032 reset=1 forces IDLE; busy, done, res_rd, sti_wr = 0; res_addr, sti_addr, sti_do, ones_cnt = 0; packer cleared.
REQ-033 Reset mid-pass aborts immediately; no sti_wr is issued after the reset cycle; a partially packed word is discarded.
REQ-034 Reset has priority over start in the same cycle.

Structure
REQ-035 The shared package dt_pkg holds IMG_W/IMG_H/WORD_W defaults, the address widths (14, 10), and the state enum type.
REQ-036 One sub-module, dt_bit_packer: 16-bit MSB-first shift register with a 4-bit fill counter and a word_valid output.
REQ-037 The FSM, address counters, threshold compare and ones counter reside in dt_pack.

Verification
REQ-038 Memory all 0, thr=0, start -> 1024 writes of 16'h0000 at addr 0..1023; ones_cnt=0; done at cycle 16387.
REQ-039 Pixel value = col (0..127), thr=63 -> each row writes words 0x0000,0x0000,0x0000,0x0000,0xFFFF,0xFFFF,0xFFFF,0xFFFF; ones_cnt=8192.
REQ-040 Only pixel 16 = 5, others 0, thr=4 -> word 1 = 16'h8000, all other words 0; ones_cnt=1.
REQ-041 thr=255 with all pixels 255 -> all words 0; a start pulse at cycle 100 has no effect on thr or counters.
REQ-042 reset asserted at cycle 5000 of a pass -> no sti_wr from cycle 5001 on; outputs zero; a new start then completes a full 1024-word pass.
REQ-043 Back-to-back passes: start in the FIN cycle is ignored; start one cycle later is accepted, with ones_cnt reset to 0 at acceptance.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared constants and types for the distance-map threshold packer.
// Address widths are sized for the default 128x128 image packed 16 pixels per word.
package dt_pkg;

  localparam int IMG_W_DEF  = 128;
  localparam int IMG_H_DEF  = 128;
  localparam int WORD_W_DEF = 16;

  localparam int RES_AW = 14;
  localparam int STI_AW = 10;
  localparam int PIX_W  = 8;
  localparam int CNT_W  = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_FIN
  } state_t;

endpackage

// File: rtl/dt_bit_packer.sv
// MSB-first serial-to-parallel packer: the first bit of a word lands in the MSB.
// word_valid pulses for one cycle after the last bit of a word is shifted in.
module dt_bit_packer
  import dt_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  localparam int FILL_W = $clog2(WORD_W);
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(WORD_W - 1);

  // Only the first WORD_W-1 bits need storing; the final bit goes straight into word.
  logic [WORD_W-2:0] sr;
  logic [FILL_W-1:0] fill;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr         <= '0;
      fill       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      sr         <= '0;
      fill       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (shift_en) begin
        sr   <= {sr[WORD_W-3:0], bit_in};
        fill <= fill + 1'b1;
        if (fill == LAST_FILL) begin
          word       <= {sr, bit_in};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dt_pack.sv
// Streams the distance map through a threshold compare and packs the resulting
// binary image into words; also counts the 1-pixels of the pass.
module dt_pack
  import dt_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  thr,
  output logic              busy,
  output logic              done,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [PIX_W-1:0]  res_di,
  output logic              sti_wr,
  output logic [STI_AW-1:0] sti_addr,
  output logic [WORD_W-1:0] sti_do,
  output logic [CNT_W-1:0]  ones_cnt
);

  localparam logic [RES_AW-1:0] LAST_PIX  = RES_AW'(IMG_W * IMG_H - 1);
  localparam logic [STI_AW-1:0] LAST_WORD = STI_AW'(IMG_W * IMG_H / WORD_W - 1);

  function automatic logic above_thr(input logic [PIX_W-1:0] d, input logic [PIX_W-1:0] t);
    return d > t;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t state, next_state;

  logic             accept;
  logic [PIX_W-1:0] thr_p0;
  logic             rd_vld_p1;
  logic             pix_bit;

  assign accept  = (state == ST_IDLE) && start;
  assign pix_bit = above_thr(res_di, thr_p0);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_READ;
      ST_READ:  if (res_addr == LAST_PIX) next_state = ST_DRAIN;
      ST_DRAIN: if (sti_wr && (sti_addr == LAST_WORD)) next_state = ST_FIN;
      ST_FIN:   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Stage 0: threshold captured once per pass, only on an accepted start.
  always_ff @(posedge clk) begin
    if (accept) thr_p0 <= thr;
  end

  // Stage 1: read issue, returning-data valid, ones count and word address.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      res_rd    <= 1'b0;
      res_addr  <= '0;
      rd_vld_p1 <= 1'b0;
      ones_cnt  <= '0;
      sti_addr  <= '0;
    end else begin
      busy      <= (next_state != ST_IDLE);
      done      <= (next_state == ST_FIN);
      res_rd    <= (next_state == ST_READ);
      rd_vld_p1 <= res_rd;
      if (accept) begin
        res_addr <= '0;
        ones_cnt <= '0;
        sti_addr <= '0;
      end else begin
        if ((state == ST_READ) && (next_state == ST_READ)) res_addr <= res_addr + 1'b1;
        if (rd_vld_p1 && pix_bit) ones_cnt <= sat_inc(ones_cnt);
        // Advances after each write so it names the word currently being written.
        if (sti_wr && (sti_addr != LAST_WORD)) sti_addr <= sti_addr + 1'b1;
      end
    end
  end

  // Stage 2: packed word and its write strobe come straight from the packer registers.
  dt_bit_packer #(
    .WORD_W(WORD_W)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept),
    .shift_en  (rd_vld_p1),
    .bit_in    (pix_bit),
    .word      (sti_do),
    .word_valid(sti_wr)
  );

endmodule

// File: tb/tb_dt_pack.sv
// Directed passes over a behavioural distance-map memory; every written word,
// its timing and the ones count are compared with a reference computed here.
module tb_dt_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  thr;
  logic        busy;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic [14:0] ones_cnt;

  always #5 clk = ~clk;

  dt_pack dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .thr     (thr),
    .busy    (busy),
    .done    (done),
    .res_rd  (res_rd),
    .res_addr(res_addr),
    .res_di  (res_di),
    .sti_wr  (sti_wr),
    .sti_addr(sti_addr),
    .sti_do  (sti_do),
    .ones_cnt(ones_cnt)
  );

  logic [7:0] mem [16384];

  always @(posedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log, owned by this process only.
  int          wr_tot = 0;
  int          wcyc  [8192];
  logic [9:0]  waddr [8192];
  logic [15:0] wdata [8192];

  always @(negedge clk) begin
    if (sti_wr === 1'b1) begin
      if (wr_tot < 8192) begin
        wcyc[wr_tot]  = cyc;
        waddr[wr_tot] = sti_addr;
        wdata[wr_tot] = sti_do;
      end
      wr_tot = wr_tot + 1;
    end
  end

  int         n_chk  = 0;
  int         n_fail = 0;
  int         s      = 0;
  int         base   = 0;
  logic [7:0] thr_m  = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input int k);
    logic [15:0] w;
    for (int j = 0; j < 16; j++) w[15-j] = (mem[16*k+j] > thr_m);
    return w;
  endfunction

  function automatic int model_ones();
    int n = 0;
    for (int i = 0; i < 16384; i++) if (mem[i] > thr_m) n++;
    return n;
  endfunction

  task automatic begin_pass(input logic [7:0] t);
    start = 1'b1;
    thr   = t;
    thr_m = t;
    s     = cyc;
    base  = wr_tot;
  endtask

  task automatic check_words(input int n);
    for (int i = 0; i < n; i++) begin
      chk("wr_cycle", 32'(wcyc[base+i] - s), 32'(16*i + 18));
      chk("wr_addr", 32'(waddr[base+i]), 32'(i));
      chk("wr_data", 32'(wdata[base+i]), 32'(model_word(i)));
    end
  endtask

  task automatic finish_pass(input int poke);
    int d = 0;
    bit got = 1'b0;
    for (int i = 0; i < 17000; i++) begin
      @(negedge clk);
      d = cyc - s;
      start = (d == poke);
      if (d == poke) thr = ~thr_m;
      if (d == 1) begin
        chk("busy_first", 32'(busy), 32'd1);
        chk("rd_first", 32'(res_rd), 32'd1);
        chk("addr_first", 32'(res_addr), 32'd0);
        chk("ones_cleared", 32'(ones_cnt), 32'd0);
      end
      if (d == 16384) begin
        chk("rd_last", 32'(res_rd), 32'd1);
        chk("addr_last", 32'(res_addr), 32'd16383);
      end
      if (d == 16385) begin
        chk("rd_stop", 32'(res_rd), 32'd0);
        chk("addr_hold", 32'(res_addr), 32'd16383);
      end
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("done_cycle", 32'(d), 32'd16387);
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("n_words", 32'(wr_tot - base), 32'd1024);
    chk("ones_cnt", 32'(ones_cnt), 32'(model_ones()));
    check_words(1024);
  endtask

  task automatic end_pass();
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd0);
    chk("ones_held", 32'(ones_cnt), 32'(model_ones()));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_res_rd"}, 32'(res_rd), 32'd0);
    chk({tag, "_sti_wr"}, 32'(sti_wr), 32'd0);
    chk({tag, "_res_addr"}, 32'(res_addr), 32'd0);
    chk({tag, "_sti_addr"}, 32'(sti_addr), 32'd0);
    chk({tag, "_sti_do"}, 32'(sti_do), 32'd0);
    chk({tag, "_ones"}, 32'(ones_cnt), 32'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0;
    thr   = 8'd0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;

    // Random pass aborted by reset at cycle 5000.
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    begin_pass(8'($urandom_range(0, 255)));
    repeat (5000) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("abort");
    chk("abort_words", 32'(wr_tot - base), 32'd312);
    check_words(312);
    seen = wr_tot;
    repeat (100) @(negedge clk);
    chk("abort_no_wr", 32'(wr_tot - seen), 32'd0);

    // All-zero map, thr=0.
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    begin_pass(8'd0);
    finish_pass(-1);
    chk("zeros_ones", 32'(ones_cnt), 32'd0);
    end_pass();

    // Column ramp, thr=63; then back-to-back into a single-pixel pass.
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i % 128);
    @(negedge clk);
    begin_pass(8'd63);
    finish_pass(-1);
    chk("cols_ones", 32'(ones_cnt), 32'd8192);
    chk("cols_word4", 32'(wdata[base+4]), 32'hFFFF);
    chk("cols_word3", 32'(wdata[base+3]), 32'h0000);
    start = 1'b1;
    thr   = 8'd0;
    @(negedge clk);
    chk("fin_start_ignored", 32'(busy), 32'd0);
    chk("fin_ones_held", 32'(ones_cnt), 32'd8192);
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    mem[16] = 8'd5;
    begin_pass(8'd4);
    finish_pass(-1);
    chk("single_ones", 32'(ones_cnt), 32'd1);
    chk("single_word1", 32'(wdata[base+1]), 32'h8000);
    end_pass();

    // All 255 with thr=255; a start with a different thr arrives mid-pass.
    for (int i = 0; i < 16384; i++) mem[i] = 8'd255;
    begin_pass(8'd255);
    finish_pass(100);
    chk("thr255_ones", 32'(ones_cnt), 32'd0);
    end_pass();

    // Random map with many zeros, thr=0: every nonzero pixel is a 1.
    for (int i = 0; i < 16384; i++) mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
    begin_pass(8'd0);
    finish_pass(-1);
    end_pass();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
